// File: rtl/instruction_fetch_if.sv
// Host/decoder-facing bundle of the fetch unit: program load, run control, fetch output, status.
// No latency of its own; wires only.
// No backpressure: the fetch side presents one instruction per RUN cycle.
interface instruction_fetch_if #(
    parameter int PC_W   = 7,
    parameter int DATA_W = 32
);
    logic              load_en;
    logic [PC_W-1:0]   load_addr;
    logic [DATA_W-1:0] load_data;
    logic              start;
    logic              halt_req;
    logic              clear;
    logic [PC_W-1:0]   next_pc;
    logic [DATA_W-1:0] instruction;
    logic [PC_W-1:0]   pc;
    logic              valid;
    logic              done;
    logic              timeout;
    logic              fault;
    logic [15:0]       retired;

    // Host / decoder side drives control and next-PC, observes fetch output and status
    modport master (
        output load_en, load_addr, load_data, start, halt_req, clear, next_pc,
        input  instruction, pc, valid, done, timeout, fault, retired
    );

    // Fetch unit side
    modport slave (
        input  load_en, load_addr, load_data, start, halt_req, clear, next_pc,
        output instruction, pc, valid, done, timeout, fault, retired
    );
endinterface

// File: rtl/instruction_fetch.sv
// CPU front end: PC register, instruction memory, host load port and IDLE/RUN/HALT control.
// Instruction is a combinational read of mem[pc]; start to first valid is 1 cycle, load visible next cycle.
// No backpressure: every RUN edge retires or halts; load_en is ignored while running.
module instruction_fetch #(
    parameter int PC_W    = 7,
    parameter int DEPTH   = 128,
    parameter int DATA_W  = 32,
    parameter int MAX_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    instruction_fetch_if.slave bus
);

    localparam int          CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_CYC > 0) ? MAX_CYC - 1 : 0);
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [PC_W-1:0]   pc_q;
    logic [15:0]       retired_q;
    logic [CNT_W-1:0]  cyc_cnt;
    logic              timeout_q, fault_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;

    logic run_init, retire, pc_ld, cnt_inc, set_fault, set_tmo, clr_flags;
    logic npc_oob, self_loop, cyc_last, mem_we;

    assign npc_oob   = 32'(bus.next_pc) >= DEPTH_U;
    assign self_loop = (bus.next_pc == pc_q);
    assign cyc_last  = (MAX_CYC != 0) && (cyc_cnt == CNT_LAST);
    // Host writes are blocked while the program is executing
    assign mem_we    = bus.load_en && (state != S_RUN) && (32'(bus.load_addr) < DEPTH_U);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state and per-edge control; RUN outcomes are mutually exclusive in priority order
    always_comb begin
        state_nx  = state;
        run_init  = 1'b0;
        retire    = 1'b0;
        pc_ld     = 1'b0;
        cnt_inc   = 1'b0;
        set_fault = 1'b0;
        set_tmo   = 1'b0;
        clr_flags = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && !bus.load_en) begin
                    state_nx  = S_RUN;
                    run_init  = 1'b1;
                    clr_flags = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.halt_req) begin
                    state_nx = S_HALT;
                end else if (npc_oob) begin
                    state_nx  = S_HALT;
                    set_fault = 1'b1;
                    retire    = 1'b1;
                end else if (self_loop) begin
                    state_nx = S_HALT;
                    retire   = 1'b1;
                end else if (cyc_last) begin
                    state_nx = S_HALT;
                    set_tmo  = 1'b1;
                    retire   = 1'b1;
                    pc_ld    = 1'b1;
                end else begin
                    pc_ld   = 1'b1;
                    retire  = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            S_HALT: begin
                // start beats clear; a simultaneous load cancels the start
                if (bus.start && !bus.load_en) begin
                    state_nx  = S_RUN;
                    run_init  = 1'b1;
                    clr_flags = 1'b1;
                end else if (bus.clear) begin
                    state_nx  = S_IDLE;
                    clr_flags = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // PC, retire counter, cycle counter and halt-cause flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            retired_q <= '0;
            cyc_cnt   <= '0;
            timeout_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            if (run_init) begin
                pc_q      <= '0;
                retired_q <= '0;
                cyc_cnt   <= '0;
            end else begin
                if (pc_ld)                          pc_q      <= bus.next_pc;
                if (retire && retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
                if (cnt_inc)                        cyc_cnt   <= cyc_cnt + 1'b1;
            end
            if (clr_flags) begin
                timeout_q <= 1'b0;
                fault_q   <= 1'b0;
            end
            if (set_fault) fault_q   <= 1'b1;
            if (set_tmo)   timeout_q <= 1'b1;
        end
    end

    // Program memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[bus.load_addr] <= bus.load_data;
    end

    assign rd_word = (32'(pc_q) < DEPTH_U) ? mem[pc_q] : '0;

    assign bus.instruction = (state == S_RUN) ? rd_word : '0;
    assign bus.pc          = pc_q;
    assign bus.valid       = (state == S_RUN);
    assign bus.done        = (state == S_HALT);
    assign bus.timeout     = timeout_q;
    assign bus.fault       = fault_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (DEPTH=100, MAX_CYC=8): table-driven program walk plus corner sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// No backpressure modelled; all waits are fixed cycle counts.
module tb_instruction_fetch;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    instruction_fetch_if #(.PC_W(7), .DATA_W(32)) bus ();

    instruction_fetch #(
        .PC_W(7), .DEPTH(100), .DATA_W(32), .MAX_CYC(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  next_pc;
        logic        halt_req;
        logic        exp_valid;
        logic [6:0]  exp_pc;
        logic [31:0] exp_instr;
        logic        exp_done;
        logic [15:0] exp_retired;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [6:0] addr, input logic [31:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        step();
        bus.load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        bus.halt_req  = 1'b0;
        bus.clear     = 1'b0;
        bus.next_pc   = '0;

        //                next halt  valid pc  instr          done retired
        vecs[0] = '{7'd1, 1'b0, 1'b1, 7'd0, 32'hA000_0000, 1'b0, 16'd0};
        vecs[1] = '{7'd2, 1'b0, 1'b1, 7'd1, 32'hA000_0001, 1'b0, 16'd1};
        vecs[2] = '{7'd3, 1'b0, 1'b1, 7'd2, 32'hA000_0002, 1'b0, 16'd2};
        vecs[3] = '{7'd3, 1'b0, 1'b1, 7'd3, 32'hA000_0003, 1'b0, 16'd3};
        vecs[4] = '{7'd0, 1'b0, 1'b0, 7'd3, 32'h0,         1'b1, 16'd4};
        vecs[5] = '{7'd9, 1'b0, 1'b0, 7'd3, 32'h0,         1'b1, 16'd4};

        // Reset state
        step();
        step();
        chk("rst_valid",   32'(bus.valid),   32'd0);
        chk("rst_done",    32'(bus.done),    32'd0);
        chk("rst_pc",      32'(bus.pc),      32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_fault",   32'(bus.fault),   32'd0);
        chk("rst_instr",   bus.instruction,  32'd0);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 10; k++) load_word(7'(k), 32'hA000_0000 + 32'(k));

        // Program walk 0..3 ending in a self-loop
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("walk%0d_valid", i),   32'(bus.valid),   32'(vecs[i].exp_valid));
            chk($sformatf("walk%0d_pc", i),      32'(bus.pc),      32'(vecs[i].exp_pc));
            chk($sformatf("walk%0d_instr", i),   bus.instruction,  vecs[i].exp_instr);
            chk($sformatf("walk%0d_done", i),    32'(bus.done),    32'(vecs[i].exp_done));
            chk($sformatf("walk%0d_retired", i), 32'(bus.retired), 32'(vecs[i].exp_retired));
            bus.next_pc  = vecs[i].next_pc;
            bus.halt_req = vecs[i].halt_req;
            step();
        end

        // HALT -> IDLE via clear
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clr_done",  32'(bus.done),  32'd0);
        chk("clr_valid", 32'(bus.valid), 32'd0);

        // start together with load in IDLE: write taken, stays IDLE
        bus.start = 1'b1;
        load_word(7'd20, 32'h5555_AAAA);
        bus.start = 1'b0;
        chk("startload_valid", 32'(bus.valid), 32'd0);
        chk("startload_done",  32'(bus.done),  32'd0);

        // Timeout after 8 valid cycles
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tmo%0d_pc", i),    32'(bus.pc),    32'(i));
            chk($sformatf("tmo%0d_valid", i), 32'(bus.valid), 32'd1);
            bus.next_pc = 7'(i + 1);
            step();
        end
        chk("tmo_done",    32'(bus.done),    32'd1);
        chk("tmo_timeout", 32'(bus.timeout), 32'd1);
        chk("tmo_fault",   32'(bus.fault),   32'd0);
        chk("tmo_retired", 32'(bus.retired), 32'd8);
        chk("tmo_pc",      32'(bus.pc),      32'd8);

        // Restart from HALT; load in RUN must not write
        pulse_start();
        chk("rs_timeout", 32'(bus.timeout), 32'd0);
        chk("rs_valid",   32'(bus.valid),   32'd1);
        chk("rs_pc",      32'(bus.pc),      32'd0);
        bus.next_pc   = 7'd20;
        bus.load_en   = 1'b1;
        bus.load_addr = 7'd2;
        bus.load_data = 32'hDEAD_BEEF;
        step();
        bus.load_en   = 1'b0;
        chk("mem20_instr", bus.instruction, 32'h5555_AAAA);
        bus.next_pc = 7'd2;
        step();
        chk("mem2_instr", bus.instruction, 32'hA000_0002);

        // Out-of-range jump faults, PC held, retire counted
        bus.next_pc = 7'd127;
        step();
        chk("flt_done",    32'(bus.done),    32'd1);
        chk("flt_fault",   32'(bus.fault),   32'd1);
        chk("flt_timeout", 32'(bus.timeout), 32'd0);
        chk("flt_pc",      32'(bus.pc),      32'd2);
        chk("flt_retired", 32'(bus.retired), 32'd3);
        chk("flt_instr",   bus.instruction,  32'd0);

        // start and clear together: start wins, flags cleared
        bus.start = 1'b1;
        bus.clear = 1'b1;
        step();
        bus.start = 1'b0;
        bus.clear = 1'b0;
        chk("sc_valid",   32'(bus.valid),   32'd1);
        chk("sc_pc",      32'(bus.pc),      32'd0);
        chk("sc_fault",   32'(bus.fault),   32'd0);
        chk("sc_retired", 32'(bus.retired), 32'd0);
        bus.next_pc = 7'd1;
        step();
        chk("sc1_retired", 32'(bus.retired), 32'd1);

        // halt_req beats a self-loop and retires nothing
        bus.next_pc  = 7'd1;
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        chk("hr_done",    32'(bus.done),    32'd1);
        chk("hr_retired", 32'(bus.retired), 32'd1);
        chk("hr_pc",      32'(bus.pc),      32'd1);
        chk("hr_fault",   32'(bus.fault),   32'd0);

        // Reset mid-RUN at pc=5
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            bus.next_pc = 7'(i + 1);
            step();
        end
        chk("pre_rst_pc",    32'(bus.pc),     32'd5);
        chk("pre_rst_instr", bus.instruction, 32'hA000_0005);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(bus.valid),   32'd0);
        chk("arst_pc",      32'(bus.pc),      32'd0);
        chk("arst_done",    32'(bus.done),    32'd0);
        chk("arst_retired", 32'(bus.retired), 32'd0);
        #1 rst_n = 1'b1;
        step();
        pulse_start();
        bus.next_pc = 7'd5;
        step();
        chk("post_rst_mem5", bus.instruction, 32'hA000_0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
